// File: rtl/i2c_adc_pkg.sv
// ----------------------------------------------------------------------------
// i2c_adc_pkg
// Shared definitions for the I2C ADC target emulation:
//   - register pointer codes
//   - FSM state encoding
//   - reset default of the config register
//   - read-back mux used when a read frame snapshots a register
// ----------------------------------------------------------------------------
package i2c_adc_pkg;

    localparam logic [1:0] PTR_CONV   = 2'b00;
    localparam logic [1:0] PTR_CONFIG = 2'b01;
    localparam logic [1:0] PTR_LO     = 2'b10;
    localparam logic [1:0] PTR_HI     = 2'b11;

    localparam logic [15:0] CONFIG_RESET_DEFAULT = 16'h8583;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_WR_PTR,
        ST_PTR_ACK,
        ST_WR_MSB,
        ST_WR_LSB,
        ST_WR_ACK,
        ST_RD_BYTE,
        ST_RD_ACK,
        ST_IGNORE
    } state_e;

    // Value returned to the master for a given pointer. OS (bit15) of the
    // config register always reads back as 1 (no conversion in progress).
    function automatic logic [15:0] read_value(input logic [1:0]  ptr,
                                               input logic [15:0] conv,
                                               input logic [15:0] cfg);
        case (ptr)
            PTR_CONV:       return conv;
            PTR_CONFIG:     return cfg | 16'h8000;
            PTR_LO, PTR_HI: return 16'h0000;
            default:        return 16'h0000;
        endcase
    endfunction

endpackage

// File: rtl/i2c_bus_sync.sv
// ----------------------------------------------------------------------------
// i2c_bus_sync
// Brings raw SCL/SDA into the clk_i domain and derives bus events.
// Each line: 2-FF synchroniser followed by a 1-deep history register.
// Ports:
//   clk_i, rst_ni   system clock, async active-low reset
//   scl_i, sda_i    raw pad levels (asynchronous)
//   scl_rise_o      1-cycle pulse on synchronised SCL rising edge
//   scl_fall_o      1-cycle pulse on synchronised SCL falling edge
//   start_o         SDA fell while SCL high (START / repeated START)
//   stop_o          SDA rose while SCL high (STOP)
//   sda_o           synchronised SDA level
// ----------------------------------------------------------------------------
module i2c_bus_sync (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic scl_i,
    input  logic sda_i,
    output logic scl_rise_o,
    output logic scl_fall_o,
    output logic start_o,
    output logic stop_o,
    output logic sda_o
);

    // [0] metastable stage, [1] synchronised level, [2] previous level
    logic [2:0] scl_pipe_q, scl_pipe_d;
    logic [2:0] sda_pipe_q, sda_pipe_d;

    always_comb begin
        scl_pipe_d = {scl_pipe_q[1:0], scl_i};
        sda_pipe_d = {sda_pipe_q[1:0], sda_i};
    end

    // NOTE: the pipes reset to 1 (idle bus level) so that reset release on an
    // idle bus produces no spurious edge, START or STOP.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            scl_pipe_q <= 3'b111;
            sda_pipe_q <= 3'b111;
        end else begin
            // NOTE: non-blocking assignments keep every flop sampling the
            // pre-edge value, so the pipe shifts one stage per clock.
            scl_pipe_q <= scl_pipe_d;
            sda_pipe_q <= sda_pipe_d;
        end
    end

    logic scl, scl_prev, sda, sda_prev;

    always_comb begin
        scl        = scl_pipe_q[1];
        scl_prev   = scl_pipe_q[2];
        sda        = sda_pipe_q[1];
        sda_prev   = sda_pipe_q[2];
        scl_rise_o = scl & ~scl_prev;
        scl_fall_o = ~scl & scl_prev;
        // SCL must be stably high across both samples for a START/STOP.
        start_o    = scl & scl_prev & sda_prev & ~sda;
        stop_o     = scl & scl_prev & ~sda_prev & sda;
        sda_o      = sda;
    end

endmodule

// File: rtl/i2c_adc_target.sv
// ----------------------------------------------------------------------------
// i2c_adc_target
// I2C target emulating a 16-bit ADC (pointer, conversion, config, thresholds).
// Ports:
//   clk_i, rst_ni   system clock (>= 20x SCL), async active-low reset
//   scl_i, sda_i    raw bus levels from the pads
//   sda_oe_o        1 = pull SDA low (open drain)
//   conv_data_i     new conversion result, loaded when conv_valid_i = 1
//   conv_valid_i    1-cycle load strobe for the conversion register
//   config_o        current config register
//   config_wr_o     1-cycle pulse on config commit
//   conv_start_o    1-cycle pulse on a config commit with OS (bit15) = 1
//   busy_o          1 from address-match ACK until the next START or STOP
// ----------------------------------------------------------------------------
module i2c_adc_target
    import i2c_adc_pkg::*;
#(
    parameter logic [6:0]  ADDRESS      = 7'h49,
    parameter logic [15:0] CONFIG_RESET = CONFIG_RESET_DEFAULT
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        scl_i,
    input  logic        sda_i,
    output logic        sda_oe_o,
    input  logic [15:0] conv_data_i,
    input  logic        conv_valid_i,
    output logic [15:0] config_o,
    output logic        config_wr_o,
    output logic        conv_start_o,
    output logic        busy_o
);

    logic scl_rise, scl_fall, start, stop, sda;

    i2c_bus_sync u_sync (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .scl_i      (scl_i),
        .sda_i      (sda_i),
        .scl_rise_o (scl_rise),
        .scl_fall_o (scl_fall),
        .start_o    (start),
        .stop_o     (stop),
        .sda_o      (sda)
    );

    state_e      state_q, state_d;
    logic [3:0]  bit_cnt_q, bit_cnt_d;      // 0..8 bits of the current byte
    logic [7:0]  shift_q, shift_d;          // received byte
    logic [7:0]  msb_q, msb_d;              // write MSB awaiting its LSB
    logic        lsb_phase_q, lsb_phase_d;  // WR_ACK is acknowledging an LSB
    logic [1:0]  ptr_q, ptr_d;
    logic [15:0] tx_q, tx_d;                // read shadow, frozen per address phase
    logic        rd_lsb_q, rd_lsb_d;        // currently sending the LSB
    logic        mack_q, mack_d;            // master ACK bit (0 = ACK)
    logic [15:0] conv_q, conv_d;
    logic [15:0] config_q, config_d;
    logic        sda_oe_q, sda_oe_d;
    logic        busy_q, busy_d;
    logic        config_wr_q, config_wr_d;
    logic        conv_start_q, conv_start_d;

    logic [7:0]  tx_byte;
    logic [2:0]  tx_idx;

    always_comb begin
        tx_byte = rd_lsb_q ? tx_q[7:0] : tx_q[15:8];
        tx_idx  = 3'd7 - bit_cnt_q[2:0];
    end

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= ST_IDLE;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            msb_q        <= '0;
            lsb_phase_q  <= 1'b0;
            ptr_q        <= PTR_CONV;
            tx_q         <= '0;
            rd_lsb_q     <= 1'b0;
            mack_q       <= 1'b1;
            conv_q       <= '0;
            config_q     <= CONFIG_RESET;
            sda_oe_q     <= 1'b0;
            busy_q       <= 1'b0;
            config_wr_q  <= 1'b0;
            conv_start_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            msb_q        <= msb_d;
            lsb_phase_q  <= lsb_phase_d;
            ptr_q        <= ptr_d;
            tx_q         <= tx_d;
            rd_lsb_q     <= rd_lsb_d;
            mack_q       <= mack_d;
            conv_q       <= conv_d;
            config_q     <= config_d;
            sda_oe_q     <= sda_oe_d;
            busy_q       <= busy_d;
            config_wr_q  <= config_wr_d;
            conv_start_q <= conv_start_d;
        end
    end

    // Next-state and datapath. sda_oe_d only changes on an SCL fall event, so
    // SDA moves one clock after the detected fall, always while SCL is low.
    always_comb begin
        // NOTE: every _d defaults to its _q first; no path leaves a variable
        // unassigned, so no latch is inferred.
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        msb_d        = msb_q;
        lsb_phase_d  = lsb_phase_q;
        ptr_d        = ptr_q;
        tx_d         = tx_q;
        rd_lsb_d     = rd_lsb_q;
        mack_d       = mack_q;
        conv_d       = conv_valid_i ? conv_data_i : conv_q;
        config_d     = config_q;
        sda_oe_d     = sda_oe_q;
        busy_d       = busy_q;
        config_wr_d  = 1'b0;
        conv_start_d = 1'b0;

        if (start) begin
            state_d   = ST_ADDR;
            bit_cnt_d = '0;
            sda_oe_d  = 1'b0;
            busy_d    = 1'b0;
        end else if (stop) begin
            state_d   = ST_IDLE;
            bit_cnt_d = '0;
            sda_oe_d  = 1'b0;
            busy_d    = 1'b0;
        end else begin
            case (state_q)
                ST_ADDR, ST_WR_PTR, ST_WR_MSB, ST_WR_LSB: begin
                    if (scl_rise && bit_cnt_q != 4'd8) begin
                        shift_d   = {shift_q[6:0], sda};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (scl_fall && bit_cnt_q == 4'd8) begin
                        // Byte complete: ACK it during the 9th SCL cycle.
                        bit_cnt_d = '0;
                        sda_oe_d  = 1'b1;
                        case (state_q)
                            ST_ADDR: begin
                                if (shift_q[7:1] == ADDRESS) begin
                                    state_d  = ST_ADDR_ACK;
                                    busy_d   = 1'b1;
                                    rd_lsb_d = 1'b0;
                                    if (shift_q[0]) tx_d = read_value(ptr_q, conv_q, config_q);
                                end else begin
                                    state_d  = ST_IGNORE;
                                    sda_oe_d = 1'b0;
                                end
                            end
                            ST_WR_PTR: begin
                                ptr_d   = shift_q[1:0];
                                state_d = ST_PTR_ACK;
                            end
                            ST_WR_MSB: begin
                                msb_d       = shift_q;
                                lsb_phase_d = 1'b0;
                                state_d     = ST_WR_ACK;
                            end
                            default: begin  // ST_WR_LSB
                                lsb_phase_d = 1'b1;
                                state_d     = ST_WR_ACK;
                            end
                        endcase
                    end
                end
                ST_ADDR_ACK: begin
                    if (scl_fall) begin
                        // shift_q still holds the address byte; bit0 is R/W.
                        if (shift_q[0]) begin
                            state_d  = ST_RD_BYTE;
                            sda_oe_d = ~tx_q[15];
                        end else begin
                            state_d  = ST_WR_PTR;
                            sda_oe_d = 1'b0;
                        end
                    end
                end
                ST_PTR_ACK: begin
                    if (scl_fall) begin
                        state_d  = ST_WR_MSB;
                        sda_oe_d = 1'b0;
                    end
                end
                ST_WR_ACK: begin
                    if (scl_fall) begin
                        sda_oe_d = 1'b0;
                        if (lsb_phase_q) begin
                            state_d = ST_WR_MSB;
                            if (ptr_q == PTR_CONFIG) begin
                                config_d     = {msb_q, shift_q};
                                config_wr_d  = 1'b1;
                                conv_start_d = msb_q[7];
                            end
                        end else begin
                            state_d = ST_WR_LSB;
                        end
                    end
                end
                ST_RD_BYTE: begin
                    if (scl_rise && bit_cnt_q != 4'd8) begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (scl_fall) begin
                        if (bit_cnt_q == 4'd8) begin
                            state_d   = ST_RD_ACK;
                            bit_cnt_d = '0;
                            sda_oe_d  = 1'b0;
                        end else begin
                            sda_oe_d = ~tx_byte[tx_idx];
                        end
                    end
                end
                ST_RD_ACK: begin
                    if (scl_rise) begin
                        mack_d = sda;
                    end else if (scl_fall) begin
                        if (!mack_q) begin
                            state_d  = ST_RD_BYTE;
                            rd_lsb_d = ~rd_lsb_q;
                            sda_oe_d = ~(rd_lsb_q ? tx_q[15] : tx_q[7]);
                        end else begin
                            state_d = ST_IGNORE;
                        end
                    end
                end
                default: ;  // ST_IDLE, ST_IGNORE: wait for START/STOP
            endcase
        end
    end

    // Outputs come straight from flops; reset clears sda_oe_o asynchronously.
    always_comb begin
        sda_oe_o     = sda_oe_q;
        config_o     = config_q;
        config_wr_o  = config_wr_q;
        conv_start_o = conv_start_q;
        busy_o       = busy_q;
    end

endmodule

// File: tb/tb_i2c_adc_target.sv
// ----------------------------------------------------------------------------
// tb_i2c_adc_target
// Bit-banged I2C master driving i2c_adc_target over a wired-AND SDA line.
// Expected bus responses (target ACK bits, read bytes) and expected config
// commits are queued as stimulus is issued; monitors pop and compare.
// ----------------------------------------------------------------------------
module tb_i2c_adc_target;

    localparam int Q = 10;  // quarter SCL period in clk cycles

    logic        clk;
    logic        rst_n;
    logic        m_scl;
    logic        m_sda;
    logic        sda_bus;
    logic        sda_oe;
    logic [15:0] conv_data;
    logic        conv_valid;
    logic [15:0] config_val;
    logic        config_wr;
    logic        conv_start;
    logic        busy;

    assign sda_bus = m_sda & ~sda_oe;

    i2c_adc_target dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .scl_i        (m_scl),
        .sda_i        (sda_bus),
        .sda_oe_o     (sda_oe),
        .conv_data_i  (conv_data),
        .conv_valid_i (conv_valid),
        .config_o     (config_val),
        .config_wr_o  (config_wr),
        .conv_start_o (conv_start),
        .busy_o       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    string       exp_name_q[$];
    logic [7:0]  exp_val_q[$];
    logic [7:0]  obs_val_q[$];
    logic [16:0] exp_cfg_q[$];   // {conv_start, config}

    logic watch     = 1'b0;
    logic seen_oe   = 1'b0;
    logic seen_busy = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Bus monitor: pairs each observed bus response with its expectation.
    always @(negedge clk) begin
        while (obs_val_q.size() > 0) begin
            logic [7:0] o;
            o = obs_val_q.pop_front();
            if (exp_val_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL bus_unexpected: got %0h expected nothing", o);
            end else begin
                string nm;
                logic [7:0] e;
                nm = exp_name_q.pop_front();
                e  = exp_val_q.pop_front();
                check(nm, {24'h0, o}, {24'h0, e});
            end
        end
    end

    // Commit monitor: every config_wr_o cycle must match a queued commit.
    always @(negedge clk) begin
        if (rst_n) begin
            if (config_wr) begin
                if (exp_cfg_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL cfg_unexpected_commit: got config %0h expected no commit", config_val);
                end else begin
                    logic [16:0] e;
                    e = exp_cfg_q.pop_front();
                    check("cfg_value", {16'h0, config_val}, {16'h0, e[15:0]});
                    check("cfg_conv_start", {31'h0, conv_start}, {31'h0, e[16]});
                end
            end else if (conv_start) begin
                n_tests++;
                n_fail++;
                $display("FAIL cfg_stray_conv_start: got 1 expected 0");
            end
        end
    end

    always @(negedge clk) begin
        if (watch && sda_oe) seen_oe = 1'b1;
        if (watch && busy)   seen_busy = 1'b1;
    end

    task automatic wait_q(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input string nm, input logic [7:0] v);
        exp_name_q.push_back(nm);
        exp_val_q.push_back(v);
    endtask

    task automatic i2c_start();
        m_sda = 1'b1; wait_q(Q);
        m_scl = 1'b1; wait_q(Q);
        m_sda = 1'b0; wait_q(Q);
        m_scl = 1'b0; wait_q(Q);
    endtask

    task automatic i2c_stop();
        m_sda = 1'b0; wait_q(Q);
        m_scl = 1'b1; wait_q(Q);
        m_sda = 1'b1; wait_q(2 * Q);
    endtask

    task automatic write_bit(input logic b);
        m_sda = b;    wait_q(Q);
        m_scl = 1'b1; wait_q(2 * Q);
        m_scl = 1'b0; wait_q(Q);
    endtask

    task automatic read_bit(output logic b);
        m_sda = 1'b1; wait_q(Q);
        m_scl = 1'b1; wait_q(Q);
        b = sda_bus;  wait_q(Q);
        m_scl = 1'b0; wait_q(Q);
    endtask

    // Master writes a byte; expected target ACK bit is 0 (ACK) or 1 (NACK).
    task automatic send_byte(input string nm, input logic [7:0] b, input logic exp_ack);
        logic a;
        push_exp(nm, {7'h0, exp_ack});
        for (int i = 7; i >= 0; i--) write_bit(b[i]);
        read_bit(a);
        obs_val_q.push_back({7'h0, a});
    endtask

    // Master reads a byte and answers with ACK (0) or NACK (1).
    task automatic recv_byte(input string nm, input logic [7:0] exp, input logic nack);
        logic [7:0] v;
        logic       b;
        push_exp(nm, exp);
        v = '0;
        for (int i = 0; i < 8; i++) begin
            read_bit(b);
            v = {v[6:0], b};
        end
        obs_val_q.push_back(v);
        write_bit(nack);
    endtask

    task automatic load_conv(input logic [15:0] v);
        @(posedge clk); #1;
        conv_data  = v;
        conv_valid = 1'b1;
        @(posedge clk); #1;
        conv_valid = 1'b0;
    endtask

    initial begin
        rst_n      = 1'b0;
        m_scl      = 1'b1;
        m_sda      = 1'b1;
        conv_data  = '0;
        conv_valid = 1'b0;
        wait_q(4);
        check("rst_sda_oe", {31'h0, sda_oe}, 32'h0);
        check("rst_config", {16'h0, config_val}, 32'h8583);
        check("rst_config_wr", {31'h0, config_wr}, 32'h0);
        check("rst_conv_start", {31'h0, conv_start}, 32'h0);
        check("rst_busy", {31'h0, busy}, 32'h0);
        rst_n = 1'b1;
        wait_q(10);

        // Read immediately after reset: pointer 00, conversion register 0.
        i2c_start();
        send_byte("rd0_addr_ack", 8'h93, 1'b0);
        recv_byte("rd0_msb", 8'h00, 1'b0);
        recv_byte("rd0_lsb", 8'h00, 1'b1);
        i2c_stop();

        // Config write 0x8403: commit with conv_start.
        i2c_start();
        send_byte("wcfg_addr_ack", 8'h92, 1'b0);
        check("wcfg_busy_after_ack", {31'h0, busy}, 32'h1);
        send_byte("wcfg_ptr_ack", 8'h01, 1'b0);
        send_byte("wcfg_msb_ack", 8'h84, 1'b0);
        exp_cfg_q.push_back({1'b1, 16'h8403});
        send_byte("wcfg_lsb_ack", 8'h03, 1'b0);
        i2c_stop();
        check("wcfg_busy_after_stop", {31'h0, busy}, 32'h0);
        check("wcfg_config_o", {16'h0, config_val}, 32'h8403);

        // Conversion read with a conv_valid between MSB and LSB.
        load_conv(16'h1234);
        i2c_start();
        send_byte("rc_addr_w_ack", 8'h92, 1'b0);
        send_byte("rc_ptr_ack", 8'h00, 1'b0);
        i2c_stop();
        i2c_start();
        send_byte("rc_addr_r_ack", 8'h93, 1'b0);
        recv_byte("rc_msb", 8'h12, 1'b0);
        load_conv(16'hABCD);
        recv_byte("rc_lsb_coherent", 8'h34, 1'b1);
        check("rc_no_drive_after_nack", {31'h0, sda_oe}, 32'h0);
        i2c_stop();
        i2c_start();
        send_byte("rc2_addr_ack", 8'h93, 1'b0);
        recv_byte("rc2_msb", 8'hAB, 1'b0);
        recv_byte("rc2_lsb", 8'hCD, 1'b1);
        i2c_stop();

        // Wrong address: never drive SDA, never go busy.
        seen_oe   = 1'b0;
        seen_busy = 1'b0;
        watch     = 1'b1;
        i2c_start();
        send_byte("wa_addr_nack", 8'h90, 1'b1);
        send_byte("wa_data_nack", 8'h01, 1'b1);
        i2c_stop();
        watch = 1'b0;
        check("wa_never_drove", {31'h0, seen_oe}, 32'h0);
        check("wa_never_busy", {31'h0, seen_busy}, 32'h0);
        check("wa_config_o", {16'h0, config_val}, 32'h8403);

        // Aborted write (STOP after MSB), then repeated START mid-pair.
        i2c_start();
        send_byte("ab_addr_ack", 8'h92, 1'b0);
        send_byte("ab_ptr_ack", 8'h01, 1'b0);
        send_byte("ab_msb_ack", 8'h12, 1'b0);
        i2c_stop();
        check("ab_config_o", {16'h0, config_val}, 32'h8403);
        i2c_start();
        send_byte("rs_addr_ack", 8'h92, 1'b0);
        send_byte("rs_ptr_ack", 8'h01, 1'b0);
        send_byte("rs_msb_ack", 8'h12, 1'b0);
        i2c_start();
        send_byte("rs2_addr_ack", 8'h92, 1'b0);
        send_byte("rs2_ptr_ack", 8'h01, 1'b0);
        send_byte("rs2_msb_ack", 8'h05, 1'b0);
        exp_cfg_q.push_back({1'b0, 16'h0583});
        send_byte("rs2_lsb_ack", 8'h83, 1'b0);
        i2c_stop();
        check("rs_config_o", {16'h0, config_val}, 32'h0583);

        // Pointer 10 reads back zero.
        i2c_start();
        send_byte("lo_addr_ack", 8'h92, 1'b0);
        send_byte("lo_ptr_ack", 8'h02, 1'b0);
        i2c_stop();
        i2c_start();
        send_byte("lo_rd_addr_ack", 8'h93, 1'b0);
        recv_byte("lo_msb", 8'h00, 1'b0);
        recv_byte("lo_lsb", 8'h00, 1'b1);
        i2c_stop();

        // Reset while the target drives the address ACK.
        i2c_start();
        for (int i = 7; i >= 0; i--) write_bit(i == 0 || i == 1 || i == 4 || i == 7);
        m_sda = 1'b1; wait_q(Q);
        m_scl = 1'b1; wait_q(Q);
        check("mr_ack_driven", {31'h0, sda_oe}, 32'h1);
        check("mr_busy", {31'h0, busy}, 32'h1);
        rst_n = 1'b0;
        #1;
        check("mr_sda_released", {31'h0, sda_oe}, 32'h0);
        check("mr_config_reset", {16'h0, config_val}, 32'h8583);
        check("mr_busy_reset", {31'h0, busy}, 32'h0);
        check("mr_config_wr_reset", {31'h0, config_wr}, 32'h0);
        wait_q(Q);
        m_scl = 1'b0; wait_q(Q);
        rst_n = 1'b1; wait_q(Q);
        m_scl = 1'b1; wait_q(2 * Q);
        i2c_start();
        send_byte("mr_wp_addr_ack", 8'h92, 1'b0);
        send_byte("mr_wp_ptr_ack", 8'h01, 1'b0);
        i2c_stop();
        i2c_start();
        send_byte("mr_rd_addr_ack", 8'h93, 1'b0);
        recv_byte("mr_cfg_msb", 8'h85, 1'b0);
        recv_byte("mr_cfg_lsb", 8'h83, 1'b1);
        i2c_stop();

        wait_q(20);
        check("bus_queue_drained", exp_val_q.size(), 32'h0);
        check("cfg_queue_drained", exp_cfg_q.size(), 32'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Safety net: the directed sequence is time-bounded, this only guards hangs.
    initial begin
        #5ms;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
